// File: rtl/irq_controller_pkg.sv
// Shared types and helpers for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_REQ,
    IRQ_SERV,
    IRQ_FIN
  } irq_state_t;

  localparam int unsigned MCAUSE_INT_BIT = 31;
  localparam int unsigned IDX_W          = 5;

  // Build an mcause value with the interrupt flag set above the cause code.
  function automatic logic [31:0] mk_mcause(input logic [30:0] code);
    logic [31:0] v;
    v                 = '0;
    v[30:0]           = code;
    v[MCAUSE_INT_BIT] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Device/core-facing signal bundle of the interrupt controller.
interface irq_controller_if #(
  parameter int unsigned INT_COUNT = 32
);
  logic [INT_COUNT-1:0] int_req_i;
  logic [INT_COUNT-1:0] mie_i;
  logic                 int_ack_i;
  logic                 mret_i;
  logic                 irq_o;
  logic [31:0]          mcause_o;
  logic [INT_COUNT-1:0] int_fin_o;

  modport master (
    output int_req_i, mie_i, int_ack_i, mret_i,
    input  irq_o, mcause_o, int_fin_o
  );

  modport slave (
    input  int_req_i, mie_i, int_ack_i, mret_i,
    output irq_o, mcause_o, int_fin_o
  );
endinterface

// File: rtl/irq_controller_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // Scan from the top down so the lowest set bit is written last.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (req[i-1]) begin
        valid = 1'b1;
        index = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: masks device levels, raises one request to the
// core, tracks the handler through mret and returns a finish pulse.
module irq_controller
  import irq_pkg::*;
#(
  parameter int unsigned INT_COUNT  = 32,
  parameter int unsigned CAUSE_BASE = 16
) (
  input logic             clk,
  input logic             rstn,
  irq_controller_if.slave bus
);

  irq_state_t           state;
  logic [IDX_W-1:0]     idx_q;
  logic                 block_q;
  logic [31:0]          mcause_q;

  logic [INT_COUNT-1:0] eff;
  logic [INT_COUNT-1:0] eff_idle;
  logic [31:0]          eff32;
  logic [31:0]          idx_onehot;
  logic                 enc_valid;
  logic [IDX_W-1:0]     enc_idx;

  // Enabled requests, with the just-finished line hidden for one IDLE cycle.
  always_comb begin
    eff        = bus.int_req_i & bus.mie_i;
    eff32      = 32'(eff);
    idx_onehot = 32'(1) << idx_q;
    eff_idle   = eff;
    if (block_q) eff_idle = eff & ~idx_onehot[INT_COUNT-1:0];
  end

  irq_prio_enc #(.N(INT_COUNT)) u_enc (
    .req   (eff_idle),
    .valid (enc_valid),
    .index (enc_idx)
  );

  // Request/service/finish sequencing; no nesting, no preemption.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IRQ_IDLE;
      idx_q    <= '0;
      block_q  <= 1'b0;
      mcause_q <= '0;
    end else begin
      case (state)
        IRQ_IDLE: begin
          block_q <= 1'b0;
          if (enc_valid) begin
            idx_q    <= enc_idx;
            mcause_q <= mk_mcause(31'(CAUSE_BASE) + 31'(enc_idx));
            state    <= IRQ_REQ;
          end
        end
        IRQ_REQ: begin
          if (bus.int_ack_i)    state <= IRQ_SERV;
          else if (!eff32[idx_q]) state <= IRQ_IDLE;
        end
        IRQ_SERV: begin
          if (bus.mret_i) state <= IRQ_FIN;
        end
        IRQ_FIN: begin
          block_q <= 1'b1;
          state   <= IRQ_IDLE;
        end
        default: state <= IRQ_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state so reset clears them at once.
  always_comb begin
    bus.irq_o     = (state == IRQ_REQ);
    bus.mcause_o  = mcause_q;
    bus.int_fin_o = '0;
    if (state == IRQ_FIN) bus.int_fin_o = idx_onehot[INT_COUNT-1:0];
  end

endmodule
